// File: rtl/flash_prog_engine.sv
// Purpose : JEDEC parallel-flash page-write engine; replays a JEDEC command buffer then a payload buffer as #WE pulses, then waits (fixed) or DQ7-polls for completion.
// Latency : busy the cycle after start; each #WE pulse is WE_LOW_CYC low + WE_HIGH_CYC high; done pulses one cycle at the end, busy drops the cycle after.
// Backpr. : none; start is ignored while busy, buffer writes only land in IDLE, and writes to a full buffer are dropped and set overflow.
// Ports   : osc/rst_n clock and sync reset; buf_clear, wbuf_*, jbuf_* buffer loading; start_addr/poll_en/start run control;
//           busy/done/error/overflow status; dut_* flash bus (addr, dout/drive, din, we_n, oe_n).
module flash_prog_engine #(
  parameter int ADDR_W           = 17,
  parameter int DATA_W           = 8,
  parameter int WBUF_DEPTH       = 128,
  parameter int JBUF_DEPTH       = 6,
  parameter int WE_LOW_CYC       = 24,
  parameter int WE_HIGH_CYC      = 24,
  parameter int FIXED_WAIT_CYC   = 8400,
  parameter int POLL_OE_CYC      = 4,
  parameter int POLL_TIMEOUT_CYC = 240000
) (
  input  logic              osc,
  input  logic              rst_n,
  input  logic              buf_clear,
  input  logic              wbuf_we,
  input  logic [DATA_W-1:0] wbuf_data,
  input  logic              jbuf_we,
  input  logic [ADDR_W-1:0] jbuf_addr,
  input  logic [DATA_W-1:0] jbuf_data,
  input  logic [ADDR_W-1:0] start_addr,
  input  logic              poll_en,
  input  logic              start,
  output logic              busy,
  output logic              done,
  output logic              error,
  output logic              overflow,
  output logic [ADDR_W-1:0] dut_addr,
  output logic [DATA_W-1:0] dut_dout,
  output logic              dut_drive,
  input  logic [DATA_W-1:0] dut_din,
  output logic              dut_we_n,
  output logic              dut_oe_n
);

  localparam int WC_W    = $clog2(WBUF_DEPTH + 1);
  localparam int JC_W    = $clog2(JBUF_DEPTH + 1);
  localparam int WI_W    = (WBUF_DEPTH > 1) ? $clog2(WBUF_DEPTH) : 1;
  localparam int JI_W    = (JBUF_DEPTH > 1) ? $clog2(JBUF_DEPTH) : 1;
  localparam int WE_MAX  = (WE_LOW_CYC > WE_HIGH_CYC) ? WE_LOW_CYC : WE_HIGH_CYC;
  localparam int CNT_MAX = (FIXED_WAIT_CYC > WE_MAX) ? FIXED_WAIT_CYC : WE_MAX;
  localparam int CNT_W   = $clog2(CNT_MAX + 1);
  localparam int TO_W    = $clog2(POLL_TIMEOUT_CYC + 1);
  localparam int PC_W    = $clog2(POLL_OE_CYC + 2);

  localparam logic [CNT_W-1:0] LOW_END  = CNT_W'(WE_LOW_CYC - 1);
  localparam logic [CNT_W-1:0] HIGH_END = CNT_W'(WE_HIGH_CYC - 1);
  localparam logic [CNT_W-1:0] WAIT_END = CNT_W'(FIXED_WAIT_CYC - 1);
  localparam logic [TO_W-1:0]  TO_END   = TO_W'(POLL_TIMEOUT_CYC - 1);
  localparam logic [PC_W-1:0]  OE_END   = PC_W'(POLL_OE_CYC - 1);
  localparam logic [PC_W-1:0]  REARM    = PC_W'(POLL_OE_CYC + 1);

  typedef enum logic [2:0] {
    S_IDLE, S_JLO, S_JHI, S_PLO, S_PHI, S_WAIT, S_POLL, S_FIN
  } state_t;

  state_t            state;
  logic [CNT_W-1:0]  cnt;
  logic [TO_W-1:0]   tcnt;
  logic [PC_W-1:0]   pcnt;
  logic              poll_en_q;
  logic [ADDR_W-1:0] start_addr_q;
  logic [WC_W-1:0]   wcount, widx;
  logic [JC_W-1:0]   jcount, jidx;

  logic [DATA_W-1:0] wbuf      [WBUF_DEPTH];
  logic [ADDR_W-1:0] jaddr_mem [JBUF_DEPTH];
  logic [DATA_W-1:0] jdata_mem [JBUF_DEPTH];

  logic            wfull, jfull, wr_w, wr_j;
  logic [WC_W-1:0] wnext, wlast;
  logic [JC_W-1:0] jnext;
  logic            poll_hit, timeout;
  logic            unused_dq;

  assign wfull = (wcount == WC_W'(WBUF_DEPTH));
  assign jfull = (jcount == JC_W'(JBUF_DEPTH));
  // buf_clear wins over same-cycle appends
  assign wr_w  = (state == S_IDLE) && !buf_clear && wbuf_we && !wfull;
  assign wr_j  = (state == S_IDLE) && !buf_clear && jbuf_we && !jfull;
  assign wnext = widx + WC_W'(1);
  assign jnext = jidx + JC_W'(1);
  assign wlast = wcount - WC_W'(1);
  // Completion: DQ7 reads back the true MSB of the last byte written
  assign poll_hit = (dut_din[DATA_W-1] == wbuf[wlast[WI_W-1:0]][DATA_W-1]);
  assign timeout  = (tcnt == TO_END);
  // Only DQ7 matters for completion; the other DQ bits are deliberately ignored
  assign unused_dq = ^dut_din[DATA_W-2:0];

  // Buffer storage has no reset: only the counts define valid contents
  always_ff @(posedge osc) begin
    if (wr_w) wbuf[wcount[WI_W-1:0]] <= wbuf_data;
    if (wr_j) begin
      jaddr_mem[jcount[JI_W-1:0]] <= jbuf_addr;
      jdata_mem[jcount[JI_W-1:0]] <= jbuf_data;
    end
  end

  always_ff @(posedge osc) begin
    if (!rst_n) begin
      state        <= S_IDLE;
      cnt          <= '0;
      tcnt         <= '0;
      pcnt         <= '0;
      poll_en_q    <= 1'b0;
      start_addr_q <= '0;
      wcount       <= '0;
      jcount       <= '0;
      widx         <= '0;
      jidx         <= '0;
      busy         <= 1'b0;
      done         <= 1'b0;
      error        <= 1'b0;
      overflow     <= 1'b0;
      dut_addr     <= '0;
      dut_dout     <= '0;
      dut_drive    <= 1'b0;
      dut_we_n     <= 1'b1;
      dut_oe_n     <= 1'b1;
    end else begin
      done <= 1'b0;

      if (state == S_IDLE) begin
        if (buf_clear) begin
          wcount   <= '0;
          jcount   <= '0;
          overflow <= 1'b0;
        end else begin
          if (wbuf_we && wfull) overflow <= 1'b1;
          if (jbuf_we && jfull) overflow <= 1'b1;
          if (wr_w) wcount <= wcount + WC_W'(1);
          if (wr_j) jcount <= jcount + JC_W'(1);
        end
      end

      case (state)
        S_IDLE: begin
          if (start) begin
            busy         <= 1'b1;
            error        <= 1'b0;
            poll_en_q    <= poll_en;
            start_addr_q <= start_addr;
            cnt          <= '0;
            jidx         <= '0;
            widx         <= '0;
            if (jcount != '0) begin
              state     <= S_JLO;
              dut_addr  <= jaddr_mem[0];
              dut_dout  <= jdata_mem[0];
              dut_drive <= 1'b1;
              dut_we_n  <= 1'b0;
            end else if (wcount != '0) begin
              state     <= S_PLO;
              dut_addr  <= start_addr;
              dut_dout  <= wbuf[0];
              dut_drive <= 1'b1;
              dut_we_n  <= 1'b0;
            end else begin
              state <= S_FIN;
              done  <= 1'b1;
            end
          end
        end

        S_JLO, S_PLO: begin
          if (cnt == LOW_END) begin
            dut_we_n <= 1'b1;
            cnt      <= '0;
            state    <= (state == S_JLO) ? S_JHI : S_PHI;
          end else begin
            cnt <= cnt + CNT_W'(1);
          end
        end

        // The payload-empty check is folded into the end of the last JEDEC
        // high phase so every #WE pulse keeps identical spacing.
        S_JHI: begin
          if (cnt == HIGH_END) begin
            cnt <= '0;
            if (jnext == jcount) begin
              if (wcount != '0) begin
                state    <= S_PLO;
                widx     <= '0;
                dut_addr <= start_addr_q;
                dut_dout <= wbuf[0];
                dut_we_n <= 1'b0;
              end else begin
                state     <= S_FIN;
                dut_drive <= 1'b0;
                done      <= 1'b1;
              end
            end else begin
              state    <= S_JLO;
              jidx     <= jnext;
              dut_addr <= jaddr_mem[jnext[JI_W-1:0]];
              dut_dout <= jdata_mem[jnext[JI_W-1:0]];
              dut_we_n <= 1'b0;
            end
          end else begin
            cnt <= cnt + CNT_W'(1);
          end
        end

        S_PHI: begin
          if (wnext == wcount) begin
            // Last pulse: cnt keeps running through WAIT so the fixed wait is
            // measured from the final #WE rise; data is held through the high phase.
            if (cnt == HIGH_END) begin
              state     <= S_WAIT;
              dut_drive <= 1'b0;
            end
            cnt <= cnt + CNT_W'(1);
          end else if (cnt == HIGH_END) begin
            state    <= S_PLO;
            cnt      <= '0;
            widx     <= wnext;
            dut_addr <= dut_addr + ADDR_W'(1);
            dut_dout <= wbuf[wnext[WI_W-1:0]];
            dut_we_n <= 1'b0;
          end else begin
            cnt <= cnt + CNT_W'(1);
          end
        end

        S_WAIT: begin
          if (poll_en_q) begin
            // One cycle with DQ released before #OE goes low
            state    <= S_POLL;
            dut_oe_n <= 1'b0;
            pcnt     <= '0;
            tcnt     <= '0;
          end else if (cnt == WAIT_END) begin
            state <= S_FIN;
            done  <= 1'b1;
          end else begin
            cnt <= cnt + CNT_W'(1);
          end
        end

        // pcnt 0..OE_END: #OE low, DQ sampled on the last low cycle;
        // then two #OE-high cycles before the next read.
        S_POLL: begin
          tcnt <= tcnt + TO_W'(1);
          if (pcnt == OE_END && poll_hit) begin
            dut_oe_n <= 1'b1;
            done     <= 1'b1;
            state    <= S_FIN;
          end else if (timeout) begin
            error    <= 1'b1;
            dut_oe_n <= 1'b1;
            done     <= 1'b1;
            state    <= S_FIN;
          end else if (pcnt == OE_END) begin
            dut_oe_n <= 1'b1;
            pcnt     <= pcnt + PC_W'(1);
          end else if (pcnt == REARM) begin
            dut_oe_n <= 1'b0;
            pcnt     <= '0;
          end else begin
            pcnt <= pcnt + PC_W'(1);
          end
        end

        S_FIN: begin
          busy      <= 1'b0;
          dut_we_n  <= 1'b1;
          dut_oe_n  <= 1'b1;
          dut_drive <= 1'b0;
          state     <= S_IDLE;
        end

        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_flash_prog_engine.sv
// Purpose : directed self-checking bench for flash_prog_engine with a DQ7 flash model.
// Latency : n/a (bench).
// Backpr. : n/a (bench).
module tb_flash_prog_engine;

  localparam int ADDR_W  = 17;
  localparam int DATA_W  = 8;
  localparam int WE_LOW  = 24;
  localparam int WE_HIGH = 24;
  localparam int FWAIT   = 8400;
  localparam int OE_CYC  = 4;
  localparam int TMO     = 64;

  localparam logic [16:0] T1_ADDR [7] = '{17'h05555, 17'h02AAA, 17'h05555,
                                          17'h1FFFE, 17'h1FFFF, 17'h00000, 17'h00001};
  localparam logic [7:0]  T1_DATA [7] = '{8'hAA, 8'h55, 8'hA0, 8'h11, 8'h22, 8'h33, 8'h44};

  logic              osc = 1'b0;
  logic              rst_n = 1'b0;
  logic              buf_clear = 1'b0;
  logic              wbuf_we = 1'b0;
  logic [DATA_W-1:0] wbuf_data = '0;
  logic              jbuf_we = 1'b0;
  logic [ADDR_W-1:0] jbuf_addr = '0;
  logic [DATA_W-1:0] jbuf_data = '0;
  logic [ADDR_W-1:0] start_addr = '0;
  logic              poll_en = 1'b0;
  logic              start = 1'b0;
  logic              busy, done, error, overflow, dut_drive, dut_we_n, dut_oe_n;
  logic [ADDR_W-1:0] dut_addr;
  logic [DATA_W-1:0] dut_dout;
  logic [DATA_W-1:0] dut_din;

  always #5 osc = ~osc;

  flash_prog_engine #(.POLL_TIMEOUT_CYC(TMO)) dut (
    .osc(osc), .rst_n(rst_n), .buf_clear(buf_clear),
    .wbuf_we(wbuf_we), .wbuf_data(wbuf_data),
    .jbuf_we(jbuf_we), .jbuf_addr(jbuf_addr), .jbuf_data(jbuf_data),
    .start_addr(start_addr), .poll_en(poll_en), .start(start),
    .busy(busy), .done(done), .error(error), .overflow(overflow),
    .dut_addr(dut_addr), .dut_dout(dut_dout), .dut_drive(dut_drive),
    .dut_din(dut_din), .dut_we_n(dut_we_n), .dut_oe_n(dut_oe_n)
  );

  int cyc = 0;
  always @(posedge osc) cyc <= cyc + 1;

  // Bus monitor: counts pulses, measures widths, logs what each #WE wrote
  int   we_cnt = 0, oe_cnt = 0, done_cnt = 0;
  int   lo_bad = 0, hi_bad = 0, oe_bad = 0, drv_bad = 0;
  int   we_fall = 0, last_rise = 0, oe_fall = 0, done_cyc = 0;
  logic had_rise = 1'b0, prev_we = 1'b1, prev_oe = 1'b1;
  logic [ADDR_W-1:0] we_addr_q [$];
  logic [DATA_W-1:0] we_dat_q  [$];
  int   oe_fall_q [$];

  always @(negedge osc) begin
    if (prev_we && !dut_we_n) begin
      we_cnt <= we_cnt + 1;
      we_addr_q.push_back(dut_addr);
      we_dat_q.push_back(dut_dout);
      we_fall <= cyc;
      if (had_rise && (cyc - last_rise != WE_HIGH)) hi_bad <= hi_bad + 1;
    end
    if (!prev_we && dut_we_n && rst_n) begin
      if (cyc - we_fall != WE_LOW) lo_bad <= lo_bad + 1;
      last_rise <= cyc;
      had_rise  <= 1'b1;
    end
    if (!dut_we_n && !dut_drive) drv_bad <= drv_bad + 1;
    if (prev_oe && !dut_oe_n) begin
      oe_cnt  <= oe_cnt + 1;
      oe_fall <= cyc;
      oe_fall_q.push_back(cyc);
    end
    if (!prev_oe && dut_oe_n && (cyc - oe_fall != OE_CYC)) oe_bad <= oe_bad + 1;
    if (done) begin
      done_cnt <= done_cnt + 1;
      done_cyc <= cyc;
      had_rise <= 1'b0;
    end
    if (!rst_n) had_rise <= 1'b0;
    prev_we <= dut_we_n;
    prev_oe <= dut_oe_n;
  end

  // Flash model: DQ7 reads the complement of the written MSB (1) until the
  // match_at-th #OE pulse of the current run; match_at=0 never completes.
  int   oe_base = 0, match_at = 0;
  logic dq7;
  always_comb begin
    dq7 = (match_at != 0) && (oe_cnt - oe_base >= match_at);
    dut_din = {dq7, 7'h00};
  end

  int total = 0, bad = 0;
  int b_we, b_oe, b_done, b_lo, b_hi, b_oeb, b_drv;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic load(input logic jwe, input logic [16:0] ja, input logic [7:0] jd,
                      input logic wwe, input logic [7:0] wd, input logic clr);
    jbuf_we = jwe; jbuf_addr = ja; jbuf_data = jd;
    wbuf_we = wwe; wbuf_data = wd; buf_clear = clr;
    @(negedge osc);
    jbuf_we = 1'b0; wbuf_we = 1'b0; buf_clear = 1'b0;
  endtask

  task automatic go(input logic [16:0] sa, input logic pe);
    start_addr = sa; poll_en = pe; start = 1'b1;
    @(negedge osc);
    start = 1'b0;
  endtask

  task automatic snap();
    b_we = we_cnt; b_oe = oe_cnt; b_done = done_cnt;
    b_lo = lo_bad; b_hi = hi_bad; b_oeb = oe_bad; b_drv = drv_bad;
    oe_base = oe_cnt;
  endtask

  task automatic wait_done(input int budget, input string tag);
    int n;
    n = 0;
    while (done_cnt == b_done && n < budget) begin
      @(negedge osc);
      n++;
    end
    @(negedge osc);
    @(negedge osc);
    chk({tag, "_done_cnt"}, done_cnt - b_done, 1);
    chk({tag, "_busy_after"}, busy, 1'b0);
  endtask

  initial begin
    repeat (3) @(negedge osc);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_error", error, 0);
    chk("rst_overflow", overflow, 0);
    chk("rst_we_n", dut_we_n, 1);
    chk("rst_oe_n", dut_oe_n, 1);
    chk("rst_drive", dut_drive, 0);
    chk("rst_addr", dut_addr, 0);
    chk("rst_dout", dut_dout, 0);
    rst_n = 1'b1;
    @(negedge osc);

    // JEDEC + payload with address wrap, fixed wait; start while busy ignored
    load(1, 17'h05555, 8'hAA, 1, 8'h11, 0);
    load(1, 17'h02AAA, 8'h55, 1, 8'h22, 0);
    load(1, 17'h05555, 8'hA0, 1, 8'h33, 0);
    load(0, 17'h0, 8'h0, 1, 8'h44, 0);
    snap();
    go(17'h1FFFE, 1'b0);
    chk("t1_busy", busy, 1);
    repeat (100) @(negedge osc);
    go(17'h00100, 1'b1);
    wait_done(10000, "t1");
    chk("t1_we_pulses", we_cnt - b_we, 7);
    for (int i = 0; i < 7; i++) begin
      chk($sformatf("t1_addr%0d", i), we_addr_q[b_we + i], T1_ADDR[i]);
      chk($sformatf("t1_data%0d", i), we_dat_q[b_we + i], T1_DATA[i]);
    end
    chk("t1_low_width", lo_bad - b_lo, 0);
    chk("t1_high_width", hi_bad - b_hi, 0);
    chk("t1_drive", drv_bad - b_drv, 0);
    chk("t1_wait", done_cyc - last_rise, FWAIT);
    chk("t1_error", error, 0);
    chk("t1_oe_pulses", oe_cnt - b_oe, 0);

    // DQ7 polling: complete on the 6th read
    load(0, 17'h0, 8'h0, 0, 8'h0, 1);
    load(0, 17'h0, 8'h0, 1, 8'h12, 0);
    load(0, 17'h0, 8'h0, 1, 8'h80, 0);
    match_at = 6;
    snap();
    go(17'h00010, 1'b1);
    wait_done(2000, "t2");
    chk("t2_we_pulses", we_cnt - b_we, 2);
    chk("t2_addr1", we_addr_q[b_we + 1], 17'h00011);
    chk("t2_oe_pulses", oe_cnt - b_oe, 6);
    chk("t2_oe_width", oe_bad - b_oeb, 0);
    chk("t2_error", error, 0);

    // Timeout: never matches
    match_at = 0;
    snap();
    go(17'h00010, 1'b1);
    wait_done(2000, "t3");
    chk("t3_error", error, 1);
    chk("t3_timeout_cyc", done_cyc - oe_fall_q[b_oe], TMO);
    chk("t3_oe_pulses", oe_cnt - b_oe, 11);
    chk("t3_oe_width", oe_bad - b_oeb, 0);

    // Next start clears error
    match_at = 1;
    snap();
    go(17'h00010, 1'b1);
    chk("t3b_err_clr", error, 0);
    chk("t3b_busy", busy, 1);
    wait_done(2000, "t3b");
    chk("t3b_error", error, 0);
    chk("t3b_oe_pulses", oe_cnt - b_oe, 1);

    // Match on the same cycle as the timeout: match wins
    match_at = 11;
    snap();
    go(17'h00010, 1'b1);
    wait_done(2000, "t4");
    chk("t4_error", error, 0);
    chk("t4_oe_pulses", oe_cnt - b_oe, 11);
    chk("t4_cyc", done_cyc - oe_fall_q[b_oe], TMO);

    // Payload overflow: 129 writes into 128 entries
    load(0, 17'h0, 8'h0, 0, 8'h0, 1);
    for (int i = 0; i < 129; i++) load(0, 17'h0, 8'h0, 1, i[7:0], 0);
    chk("t5_overflow", overflow, 1);
    snap();
    go(17'h00000, 1'b0);
    wait_done(16000, "t5");
    chk("t5_we_pulses", we_cnt - b_we, 128);
    chk("t5_last_addr", we_addr_q[b_we + 127], 17'h0007F);
    chk("t5_last_data", we_dat_q[b_we + 127], 8'h7F);
    chk("t5_low_width", lo_bad - b_lo, 0);
    chk("t5_high_width", hi_bad - b_hi, 0);
    load(0, 17'h0, 8'h0, 0, 8'h0, 1);
    chk("t5_ovf_clr", overflow, 0);

    // Empty payload (clear beats a same-cycle write), JEDEC only, poll_en=1
    load(0, 17'h0, 8'h0, 1, 8'h55, 1);
    load(1, 17'h05555, 8'hAA, 0, 8'h0, 0);
    load(1, 17'h02AAA, 8'h55, 0, 8'h0, 0);
    load(1, 17'h05555, 8'h80, 0, 8'h0, 0);
    match_at = 0;
    snap();
    go(17'h00000, 1'b1);
    wait_done(1000, "t6");
    chk("t6_we_pulses", we_cnt - b_we, 3);
    chk("t6_oe_pulses", oe_cnt - b_oe, 0);
    chk("t6_no_wait", done_cyc - last_rise, WE_HIGH);
    chk("t6_error", error, 0);

    // Reset during a payload pulse
    load(0, 17'h0, 8'h0, 0, 8'h0, 1);
    for (int i = 0; i < 4; i++) load(0, 17'h0, 8'h0, 1, 8'hC0 + i[7:0], 0);
    snap();
    go(17'h00100, 1'b0);
    begin
      int n;
      n = 0;
      while (dut_we_n && n < 10) begin
        @(negedge osc);
        n++;
      end
    end
    chk("t7_in_plo", dut_we_n, 0);
    repeat (5) @(negedge osc);
    rst_n = 1'b0;
    @(negedge osc);
    chk("t7_we_n", dut_we_n, 1);
    chk("t7_busy", busy, 0);
    chk("t7_drive", dut_drive, 0);
    chk("t7_addr", dut_addr, 0);
    rst_n = 1'b1;
    @(negedge osc);
    snap();
    go(17'h00100, 1'b0);
    wait_done(100, "t7");
    chk("t7_counts_zero", we_cnt - b_we, 0);
    chk("t7_overflow", overflow, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/flash_prog_engine.md
Name: flash_prog_engine

Overview:
- Parametrised JEDEC parallel-flash page-write engine for ZIF bottomhalf bitfiles.
- Host-side register decode loads a JEDEC command buffer and a payload buffer, then issues start. The engine sequences #WE pulses on the DUT bus.
- Completion is detected by one of two methods: a fixed wait (legacy), or DQ7 data polling with timeout and error status (new).
- Sits between the microcontroller register decode and the zif bufif0 pin mapping.

Parameters:
- ADDR_W, 17, DUT address width.
- DATA_W, 8, DUT data width; DQ(DATA_W-1) is the poll bit.
- WBUF_DEPTH, 128, payload buffer entries.
- JBUF_DEPTH, 6, JEDEC command buffer entries.
- WE_LOW_CYC, 24, #WE low time in osc cycles (1us at 24MHz).
- WE_HIGH_CYC, 24, #WE high time between pulses.
- FIXED_WAIT_CYC, 8400, post-write wait when poll_en=0 (350us).
- POLL_OE_CYC, 4, #OE low time before sampling DQ.
- POLL_TIMEOUT_CYC, 240000, maximum polling time (10ms).

Ports:
- osc  in  1  24MHz clock; all logic on posedge.
- rst_n  in  1  synchronous active-low reset.
- buf_clear  in  1  pulse: clears both buffer counts and overflow.
- wbuf_we  in  1  pulse: append wbuf_data to payload buffer.
- wbuf_data  in  DATA_W  payload byte.
- jbuf_we  in  1  pulse: append {jbuf_addr, jbuf_data} to JEDEC buffer.
- jbuf_addr  in  ADDR_W  JEDEC command address.
- jbuf_data  in  DATA_W  JEDEC command data.
- start_addr  in  ADDR_W  payload start address; sampled on start.
- poll_en  in  1  1=DQ7 polling, 0=fixed wait; sampled on start.
- start  in  1  pulse: run a sequence.
- busy  out  1  sequence in progress.
- done  out  1  one-cycle pulse when a sequence ends.
- error  out  1  sticky timeout flag; cleared on start.
- overflow  out  1  sticky: a buffer write was attempted while that buffer was full.
- dut_addr  out  ADDR_W  DUT address.
- dut_dout  out  DATA_W  data driven to the DUT.
- dut_drive  out  1  1 = FPGA drives DQ.
- dut_din  in  DATA_W  DQ pins as read back.
- dut_we_n  out  1  DUT #WE.
- dut_oe_n  out  1  DUT #OE.

Behaviour:
- Reset (rst_n=0 on a clock edge, including mid-sequence):
  - Outputs: busy=0, done=0, error=0, overflow=0, dut_we_n=1, dut_oe_n=1, dut_drive=0, dut_addr=0, dut_dout=0.
  - Buffer counts 0; state IDLE.
- Buffer loading:
  - Accepted only in IDLE.
  - A write to a full buffer is dropped and sets overflow.
  - wbuf_we and jbuf_we may be asserted in the same cycle; both are accepted.
  - buf_clear has priority over same-cycle buffer writes.
  - Buffer contents persist across sequences until buf_clear.
- start:
  - Ignored while busy.
  - In IDLE: latch start_addr and poll_en, clear error; busy=1 from the next cycle.
- IDLE -> JLO if jcount>0, else -> PCHK.
- JLO:
  - dut_addr=jaddr[i], dut_dout=jdata[i], dut_drive=1, dut_we_n=0.
  - Hold WE_LOW_CYC cycles -> JHI.
- JHI:
  - dut_we_n=1 for WE_HIGH_CYC cycles; i++.
  - If i==jcount -> PCHK, else -> JLO.
- PCHK:
  - wcount==0 -> FIN (no wait, no poll).
  - Otherwise dut_addr=start_addr -> PLO.
- PLO / PHI:
  - Same timing as JLO / JHI, using wbuf[k].
  - After PHI: if k==wcount -> WAIT; otherwise dut_addr+1 (wraps modulo 2^ADDR_W) -> PLO.
- WAIT:
  - dut_drive=0; dut_addr holds the last written address.
  - poll_en=0: FIXED_WAIT_CYC cycles -> FIN.
  - poll_en=1 -> POLL.
- POLL:
  - Each poll: dut_oe_n=0 for POLL_OE_CYC cycles, then sample dut_din on the last low cycle, then dut_oe_n=1 for 2 cycles.
  - Sampled DQ(DATA_W-1) == wbuf[wcount-1][DATA_W-1] -> FIN.
  - Timeout counter starts on entry to POLL. On reaching POLL_TIMEOUT_CYC: set error, dut_oe_n=1 -> FIN.
  - If the match and the timeout occur in the same cycle, the match wins (error stays 0).
- FIN:
  - dut_we_n=1, dut_oe_n=1, dut_drive=0; done=1 for one cycle; busy=0 the next cycle; -> IDLE.
- Counters are sized by $clog2(depth+1) so that exactly depth entries are representable.
- Read path is outside this block: dut_addr is muxed externally while busy=0.

Test Plan:
- JEDEC sequence: 3 JEDEC entries (5555/AA, 2AAA/55, 5555/A0), 4 payload bytes, start_addr=0x1FFFE, poll_en=0 -> required response:
  - 7 #WE pulses, each 24 cycles low and 24 high.
  - Payload addresses 1FFFE, 1FFFF, 00000, 00001.
  - done exactly 8400 cycles after the last #WE rise; error=0.
- DQ7 polling: poll_en=1, last byte 0x80; DUT model returns DQ7=0 for 5 polls, then 1 -> required response:
  - Exactly 6 #OE pulses of 4 cycles each; done pulse; error=0.
- Poll timeout: poll_en=1, DUT model never matches -> required response:
  - error=1 and done after POLL_TIMEOUT_CYC.
  - The next start clears error.
- Buffer overflow: 129 wbuf_we pulses with WBUF_DEPTH=128 -> required response:
  - overflow=1; wcount=128; 128 payload #WE pulses.
  - buf_clear then clears overflow.
- Empty payload: 3 JEDEC entries, wcount=0 -> required response:
  - 3 #WE pulses, then done with no wait and no #OE pulse.
- Reset and busy rules:
  - rst_n=0 during PLO -> dut_we_n=1 and busy=0 on the next edge; buffer counts 0.
  - start asserted while busy -> ignored.
